// File: rtl/matrix_mul_pkg.sv
// Shared types for the matrix_mul sequencer: word and 8x8 matrix views
// and the sequencer state encoding.
package matrix_mul_pkg;
   localparam int MAT_DIM   = 8;
   localparam int MAT_ELEMS = MAT_DIM * MAT_DIM;
   localparam int WORD_W    = 32;
   localparam int IDX_W     = $clog2(MAT_ELEMS);

   typedef logic [WORD_W-1:0] word_t;
   typedef word_t [0:MAT_ELEMS-1] mat_t;

   typedef enum logic [2:0] {
      LOAD_A,
      LOAD_B,
      CLEAR,
      RUN,
      SETTLE,
      ABORT,
      DRAIN
   } seq_state_t;
endpackage

// File: rtl/mat_buf64.sv
// 64x32 register file: indexed write, whole-array load, parallel and
// indexed read. Cleared by the asynchronous reset.
module mat_buf64
   import matrix_mul_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [IDX_W-1:0] idx,
   input  word_t            wdata,
   input  logic             load_all,
   input  mat_t             din,
   output mat_t             dout,
   input  logic [IDX_W-1:0] rd_idx,
   output word_t            rdata
);
   mat_t mem;

   // Whole-array load wins over a single-word write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem <= '0;
      end else if (load_all) begin
         mem <= din;
      end else if (we) begin
         mem[idx] <= wdata;
      end
   end

   assign dout  = mem;
   assign rdata = mem[rd_idx];
endmodule

// File: rtl/matrix_mul_seq.sv
// Sequencer around matrix_mul: streams A and B in, runs the multiply with a
// watchdog, captures C after a settle delay and streams it back out.
module matrix_mul_seq
   import matrix_mul_pkg::*;
#(
   parameter int MAT_DIM     = 8,
   parameter int DONE_SETTLE = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic  clk,
   input  logic  reset,
   input  word_t in_data,
   input  logic  in_valid,
   output logic  in_ready,
   output word_t out_data,
   output logic  out_valid,
   input  logic  out_ready,
   output logic  out_last,
   output logic  busy,
   output logic  err,
   output mat_t  mm_a,
   output mat_t  mm_b,
   output logic  mm_clear,
   output logic  mm_start,
   input  mat_t  mm_c,
   input  logic  mm_done
);
   localparam int ELEMS  = MAT_DIM * MAT_DIM;
   localparam int WDOG_W = $clog2(TIMEOUT + 1);

   seq_state_t        state;
   logic [IDX_W-1:0]  idx;
   logic [WDOG_W-1:0] wdog;
   logic [3:0]        set_cnt;
   logic              in_beat;
   logic              out_beat;
   logic              last_idx;
   logic              capture;
   word_t             c_rdata;
   word_t             a_rd_unused;
   word_t             b_rd_unused;
   mat_t              c_arr_unused;

   assign last_idx  = (idx == IDX_W'(ELEMS - 1));
   assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
   assign in_beat   = in_valid && in_ready;
   assign out_valid = (state == DRAIN);
   assign out_beat  = out_valid && out_ready;
   assign out_data  = out_valid ? c_rdata : '0;
   assign out_last  = out_valid && last_idx;
   assign busy      = !((state == LOAD_A) && (idx == '0));
   // matrix_mul is held cleared for the whole reset, not just after it.
   assign mm_clear  = reset || (state == CLEAR) || (state == ABORT);
   assign mm_start  = (state == RUN) || (state == SETTLE);
   assign capture   = (state == SETTLE) && (set_cnt == 4'(DONE_SETTLE - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= LOAD_A;
         idx     <= '0;
         wdog    <= '0;
         set_cnt <= '0;
         err     <= 1'b0;
      end else begin
         case (state)
            LOAD_A: if (in_beat) begin
               idx <= idx + 1'b1;
               if (last_idx) state <= LOAD_B;
            end
            LOAD_B: if (in_beat) begin
               idx <= idx + 1'b1;
               if (last_idx) state <= CLEAR;
            end
            CLEAR: begin
               wdog  <= '0;
               state <= RUN;
            end
            RUN: begin
               if (mm_done) begin
                  set_cnt <= '0;
                  state   <= SETTLE;
               end else if (wdog == WDOG_W'(TIMEOUT)) begin
                  err   <= 1'b1;
                  state <= ABORT;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            SETTLE: begin
               if (capture) begin
                  idx   <= '0;
                  state <= DRAIN;
               end else begin
                  set_cnt <= set_cnt + 1'b1;
               end
            end
            DRAIN: if (out_beat) begin
               idx <= idx + 1'b1;
               if (last_idx) state <= LOAD_A;
            end
            ABORT:   state <= LOAD_A;
            default: state <= LOAD_A;
         endcase
      end
   end

   mat_buf64 u_a_buf (
      .clk      (clk),
      .reset    (reset),
      .we       (in_beat && (state == LOAD_A)),
      .idx      (idx),
      .wdata    (in_data),
      .load_all (1'b0),
      .din      ('0),
      .dout     (mm_a),
      .rd_idx   (idx),
      .rdata    (a_rd_unused)
   );

   mat_buf64 u_b_buf (
      .clk      (clk),
      .reset    (reset),
      .we       (in_beat && (state == LOAD_B)),
      .idx      (idx),
      .wdata    (in_data),
      .load_all (1'b0),
      .din      ('0),
      .dout     (mm_b),
      .rd_idx   (idx),
      .rdata    (b_rd_unused)
   );

   mat_buf64 u_c_buf (
      .clk      (clk),
      .reset    (reset),
      .we       (1'b0),
      .idx      (idx),
      .wdata    ('0),
      .load_all (capture),
      .din      (mm_c),
      .dout     (c_arr_unused),
      .rd_idx   (idx),
      .rdata    (c_rdata)
   );
endmodule

// File: tb/tb_matrix_mul_seq.sv
// Bench for matrix_mul_seq: randomized streams, a behavioural matrix_mul and
// a scoreboard built from the accepted input words.
module tb_matrix_mul_seq;
   import matrix_mul_pkg::*;

   localparam int TO     = 16;
   localparam int SETTLE = 3;

   logic  clk;
   logic  reset;
   word_t in_data;
   logic  in_valid;
   logic  in_ready;
   word_t out_data;
   logic  out_valid;
   logic  out_ready;
   logic  out_last;
   logic  busy;
   logic  err;
   mat_t  mm_a;
   mat_t  mm_b;
   logic  mm_clear;
   logic  mm_start;
   mat_t  mm_c;
   logic  mm_done;

   int n_checks = 0;
   int n_err    = 0;

   matrix_mul_seq #(.MAT_DIM(8), .DONE_SETTLE(SETTLE), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy),
      .err       (err),
      .mm_a      (mm_a),
      .mm_b      (mm_b),
      .mm_clear  (mm_clear),
      .mm_start  (mm_start),
      .mm_c      (mm_c),
      .mm_done   (mm_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic mat_t mat_prod(input mat_t a, input mat_t b);
      mat_t  c;
      word_t s;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            s = '0;
            for (int k = 0; k < 8; k++) s += a[i*8+k] * b[k*8+j];
            c[i*8+j] = s;
         end
      end
      return c;
   endfunction

   // Behavioural matrix_mul: done after a random latency, held until clear.
   // C is only correct exactly SETTLE cycles after done is first sampled.
   logic mm_hang = 1'b0;
   logic mdl_clr, mdl_st, mdone;
   int   lat, lat_cnt, since;
   mat_t prod;

   initial begin
      mm_done = 1'b0;
      mm_c    = '0;
      mdone   = 1'b0;
      lat     = 1;
      lat_cnt = 0;
      since   = 0;
      prod    = '0;
      forever begin
         @(negedge clk);
         mdl_clr = mm_clear;
         mdl_st  = mm_start;
         @(posedge clk);
         #1;
         if (mdl_clr) begin
            mdone   = 1'b0;
            lat_cnt = 0;
            since   = 0;
            lat     = $urandom_range(1, 10);
         end else if (mdl_st && !mdone) begin
            lat_cnt++;
            if (lat_cnt >= lat && !mm_hang) begin
               mdone = 1'b1;
               since = 0;
               prod  = mat_prod(mm_a, mm_b);
            end
         end else if (mdone && since < 15) begin
            since++;
         end
         mm_done = mdone;
         for (int k = 0; k < 64; k++)
            mm_c[k] = (mdone && since == SETTLE) ? prod[k] : (prod[k] ^ {16'hA5C3, 8'(since), 8'h01});
      end
   end

   // Scoreboard and per-cycle compare process.
   word_t in_q[$];
   word_t exp_q[$];
   word_t out_log[64];
   logic  running   = 1'b0;
   logic  hang_job  = 1'b0;
   logic  err_exp   = 1'b0;
   logic  stall_prev = 1'b0;
   word_t prev_data = '0;
   int    hang_cnt  = 0;
   int    out_pos   = 0;

   always @(negedge clk) begin
      mat_t ma, mb, mc;
      if (reset) begin
         in_q.delete();
         exp_q.delete();
         running    = 1'b0;
         hang_job   = 1'b0;
         err_exp    = 1'b0;
         stall_prev = 1'b0;
         out_pos    = 0;
      end else begin
         chk("in_ready", in_ready, running ? 0 : 1);
         chk("busy", busy, (running || in_q.size() != 0) ? 1 : 0);
         if (!running) chk("err", err, err_exp);
         if (out_valid) begin
            if (!running || hang_job || exp_q.size() == 0) begin
               chk("spurious_out_valid", out_valid, 0);
            end else begin
               chk("out_data", out_data, exp_q[0]);
               chk("out_last", out_last, (out_pos == 63) ? 1 : 0);
            end
            if (stall_prev) chk("stall_stable", out_data, prev_data);
         end else if (stall_prev) begin
            chk("stall_valid_held", out_valid, 1);
         end
         stall_prev = out_valid && !out_ready;
         prev_data  = out_data;
         if (out_valid && out_ready && exp_q.size() > 0) begin
            if (out_pos < 64) out_log[out_pos] = exp_q[0] ^ exp_q[0] ^ out_data;
            void'(exp_q.pop_front());
            out_pos++;
            if (exp_q.size() == 0) running = 1'b0;
         end
         if (running && hang_job) begin
            hang_cnt--;
            if (hang_cnt == 0) begin
               running = 1'b0;
               err_exp = 1'b1;
            end
         end
         if (in_valid && in_ready) begin
            in_q.push_back(in_data);
            if (in_q.size() == 128) begin
               for (int k = 0; k < 64; k++) begin
                  ma[k] = in_q[k];
                  mb[k] = in_q[64+k];
               end
               in_q.delete();
               running  = 1'b1;
               hang_job = mm_hang;
               out_pos  = 0;
               if (mm_hang) begin
                  hang_cnt = TO + 3;
               end else begin
                  mc = mat_prod(ma, mb);
                  for (int k = 0; k < 64; k++) exp_q.push_back(mc[k]);
               end
            end
         end
      end
   end

   // Output backpressure: 0 always ready, 1 toggling, 2 random.
   int rdy_mode = 0;
   logic rdy_tg = 1'b0;
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         rdy_tg = !rdy_tg;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = rdy_tg;
            default: out_ready = ($urandom_range(0, 1) == 1);
         endcase
      end
   end

   word_t tx_q[$];

   // Input stream: mode 0 valid constant, 1 toggling 1-0, 2 random bubbles.
   task automatic drive(input int mode, input int n);
      int   i = 0;
      int   cyc = 0;
      logic v;
      while (i < n && cyc < 20000) begin
         @(posedge clk);
         #1;
         v = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : ($urandom_range(0, 3) != 0);
         in_valid = v;
         in_data  = tx_q[i];
         @(negedge clk);
         if (v && in_ready) i++;
         cyc++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (i < n) chk("drive_timeout", i, n);
   endtask

   task automatic wait_idle(input int bound);
      int c = 0;
      do begin
         @(posedge clk);
         c++;
      end while (running && c < bound);
      if (running) chk("idle_timeout", c, bound);
      repeat (2) @(posedge clk);
      #1;
   endtask

   int st_cyc, clr_after, ov_cnt;
   logic seen_start;

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_err);
      $fatal(1, "global timeout");
   end

   initial begin
      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      #1 reset = 1'b1;
      #2;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_mm_clear", mm_clear, 1);
      chk("rst_mm_start", mm_start, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mm_a_zero", (mm_a == '0) ? 1 : 0, 1);
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      #1 chk("post_rst_mm_clear", mm_clear, 0);

      // Identity A, B[k]=k+1: output must equal B row-major.
      tx_q.delete();
      for (int k = 0; k < 64; k++) tx_q.push_back((k % 9 == 0) ? 32'd1 : 32'd0);
      for (int k = 0; k < 64; k++) tx_q.push_back(32'(k + 1));
      rdy_mode = 0;
      drive(0, 128);
      wait_idle(2000);
      for (int k = 0; k < 64; k += 9) chk("ident_lit", out_log[k], 32'(k + 1));
      chk("ident_lit_last", out_log[63], 64);
      chk("ident_busy_after", busy, 0);
      chk("ident_err_after", err, 0);

      // All-2 times all-3 under toggling valid and ready.
      tx_q.delete();
      for (int k = 0; k < 64; k++) tx_q.push_back(32'd2);
      for (int k = 0; k < 64; k++) tx_q.push_back(32'd3);
      rdy_mode = 1;
      drive(1, 128);
      wait_idle(2000);
      chk("bp_lit_first", out_log[0], 48);
      chk("bp_lit_mid", out_log[31], 48);
      chk("bp_lit_last", out_log[63], 48);

      // Two random jobs back to back with in_valid held: early data waits.
      tx_q.delete();
      for (int k = 0; k < 256; k++) tx_q.push_back($urandom());
      rdy_mode = 2;
      drive(0, 256);
      wait_idle(2000);

      // Random job with random bubbles on both sides.
      tx_q.delete();
      for (int k = 0; k < 128; k++) tx_q.push_back($urandom());
      drive(2, 128);
      wait_idle(2000);

      // Watchdog: matrix_mul never answers.
      mm_hang = 1'b1;
      rdy_mode = 0;
      tx_q.delete();
      for (int k = 0; k < 128; k++) tx_q.push_back($urandom());
      drive(0, 128);
      st_cyc = 0;
      clr_after = 0;
      ov_cnt = 0;
      seen_start = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (mm_start) begin
            st_cyc++;
            seen_start = 1'b1;
         end
         if (mm_clear && seen_start && !mm_start) clr_after++;
         if (out_valid) ov_cnt++;
      end
      chk("to_start_cycles", st_cyc, TO + 1);
      chk("to_clear_pulse", clr_after, 1);
      chk("to_no_output", ov_cnt, 0);
      chk("to_err", err, 1);
      chk("to_in_ready", in_ready, 1);
      mm_hang = 1'b0;

      // Normal job after abort: err stays sticky.
      tx_q.delete();
      for (int k = 0; k < 128; k++) tx_q.push_back($urandom_range(0, 1000));
      rdy_mode = 2;
      drive(2, 128);
      wait_idle(2000);
      chk("err_sticky", err, 1);

      // Reset in the middle of loading A, then a fresh I*I job.
      tx_q.delete();
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < 64; k++) tx_q.push_back((k % 9 == 0) ? 32'd1 : 32'd0);
      rdy_mode = 0;
      drive(0, 40);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_mm_clear", mm_clear, 1);
      chk("mid_rst_mm_a_zero", (mm_a == '0) ? 1 : 0, 1);
      chk("mid_rst_err", err, 0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      drive(0, 128);
      wait_idle(2000);
      for (int k = 0; k < 64; k++)
         chk("rst_ident_lit", out_log[k], (k % 9 == 0) ? 32'd1 : 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
